// File: rtl/pd_hdr_pkg.sv
// Shared types and default byte map for the block header store.
// Header bytes come first in the address space, then the difficulty target.
package pd_hdr_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    VALID,
    MINING
  } state_t;

  localparam int HDR_BYTES_D    = 80;
  localparam int CHUNK1_BYTES_D = 64;
  localparam int DIFF_BYTES_D   = 32;
  localparam int NONCE_OFS_D    = 76;

endpackage

// File: rtl/pd_nonce_adder.sv
// Combinational 32-bit nonce step with carry out of bit 31.
// The carry is what marks the nonce space as used up.
module pd_nonce_adder #(
  parameter int STEP = 1
) (
  input  logic [31:0] a,
  output logic [31:0] sum,
  output logic        carry
);

  assign {carry, sum} = {1'b0, a} + 33'(STEP);

endmodule

// File: rtl/pd_header_store.sv
// Byte-loaded header and difficulty store with fill tracking,
// mining lock and in-place little-endian nonce stepping.
module pd_header_store
  import pd_hdr_pkg::*;
#(
  parameter int HDR_BYTES    = HDR_BYTES_D,
  parameter int CHUNK1_BYTES = CHUNK1_BYTES_D,
  parameter int DIFF_BYTES   = DIFF_BYTES_D,
  parameter int NONCE_OFS    = NONCE_OFS_D,
  parameter int NONCE_STEP   = 1,
  localparam int TOTAL = HDR_BYTES + DIFF_BYTES,
  localparam int AW    = $clog2(TOTAL)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 i_data_en,
  input  logic [AW-1:0]        i_data_sel,
  input  logic [7:0]           i_data,
  output logic                 wr_err,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  input  logic                 release_hdr,
  input  logic                 increment,
  output logic                 nonce_exhausted,
  output logic [CHUNK1_BYTES*8-1:0] chunk_1,
  output logic [(HDR_BYTES-CHUNK1_BYTES)*8-1:0] chunk_2,
  output logic [DIFF_BYTES*8-1:0] difficulty,
  output logic [31:0]          nonce
);

  state_t state_q, state_d;

  logic [TOTAL-1:0][7:0] mem_q;
  logic [TOTAL-1:0]      mask_q;
  logic [TOTAL-1:0]      wr_hot;

  logic        in_range;
  logic        mining;
  logic        wr_ok;
  logic        wr_bad;
  logic        nonce_hit;
  logic        inc_ok;
  logic        mask_full;
  logic        carry;
  logic [31:0] nonce_sum;
  logic [31:0] sel_w;

  assign sel_w    = 32'(i_data_sel);
  assign in_range = sel_w < TOTAL;
  assign mining   = state_q == MINING;

  assign wr_ok  = i_data_en & ~clear
                & in_range & ~mining;
  assign wr_bad = i_data_en & ~clear
                & (~in_range | mining);

  assign wr_hot = wr_ok ? (TOTAL'(1) << i_data_sel)
                        : '0;

  // Completion must see the write landing this cycle.
  assign mask_full = &(mask_q | wr_hot);

  assign nonce_hit = wr_ok
                   & (sel_w >= NONCE_OFS)
                   & (sel_w < NONCE_OFS + 4);

  assign inc_ok = increment & ~clear
                & mining & ~nonce_exhausted;

  pd_nonce_adder #(
    .STEP (NONCE_STEP)
  ) u_adder (
    .a     (nonce),
    .sum   (nonce_sum),
    .carry (carry)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:
        if (wr_ok)
          state_d = mask_full ? VALID : FILL;
      FILL:
        if (wr_ok && mask_full)
          state_d = VALID;
      VALID:
        if (hdr_ready)
          state_d = MINING;
      MINING:
        if (release_hdr)
          state_d = VALID;
      default:
        state_d = EMPTY;
    endcase
    if (clear)
      state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q           <= '0;
      mask_q          <= '0;
      wr_err          <= 1'b0;
      nonce_exhausted <= 1'b0;
    end else if (clear) begin
      mem_q           <= '0;
      mask_q          <= '0;
      wr_err          <= 1'b0;
      nonce_exhausted <= 1'b0;
    end else begin
      wr_err <= wr_bad;
      mask_q <= mask_q | wr_hot;
      if (wr_ok)
        mem_q[i_data_sel] <= i_data;
      if (inc_ok)
        mem_q[NONCE_OFS +: 4] <= nonce_sum;
      // Rewriting any nonce byte starts a fresh nonce range.
      if (nonce_hit)
        nonce_exhausted <= 1'b0;
      else if (inc_ok && carry)
        nonce_exhausted <= 1'b1;
    end
  end

  assign hdr_valid  = state_q == VALID;
  assign chunk_1    = mem_q[CHUNK1_BYTES-1:0];
  assign chunk_2    = mem_q[HDR_BYTES-1:CHUNK1_BYTES];
  assign difficulty = mem_q[TOTAL-1:HDR_BYTES];
  assign nonce      = mem_q[NONCE_OFS +: 4];

endmodule

// File: tb/tb_pd_header_store.sv
// Scoreboard bench for pd_header_store (step 1 and step 4 instances).
module tb_pd_header_store;

  localparam int AW = 7;

  localparam int O_WERR  = 0;
  localparam int O_VALID = 1;
  localparam int O_EXH   = 2;
  localparam int O_NONCE = 3;
  localparam int O_NON4  = 4;
  localparam int O_EXH4  = 5;
  localparam int O_BYTE  = 6;
  localparam int O_WERR4 = 7;

  typedef struct {
    string       tag;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear;
  logic          i_data_en;
  logic [AW-1:0] i_data_sel;
  logic [7:0]    i_data;
  logic          hdr_ready;
  logic          release_hdr;
  logic          increment;

  logic          wr_err, hdr_valid, exh;
  logic [511:0]  chunk_1;
  logic [127:0]  chunk_2;
  logic [255:0]  difficulty;
  logic [31:0]   nonce;

  logic          wr_err4, hdr_valid4, exh4;
  logic [511:0]  chunk_1_4;
  logic [127:0]  chunk_2_4;
  logic [255:0]  difficulty_4;
  logic [31:0]   nonce4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pd_header_store u_dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear           (clear),
    .i_data_en       (i_data_en),
    .i_data_sel      (i_data_sel),
    .i_data          (i_data),
    .wr_err          (wr_err),
    .hdr_valid       (hdr_valid),
    .hdr_ready       (hdr_ready),
    .release_hdr     (release_hdr),
    .increment       (increment),
    .nonce_exhausted (exh),
    .chunk_1         (chunk_1),
    .chunk_2         (chunk_2),
    .difficulty      (difficulty),
    .nonce           (nonce)
  );

  pd_header_store #(
    .NONCE_STEP (4)
  ) u_dut4 (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear           (clear),
    .i_data_en       (i_data_en),
    .i_data_sel      (i_data_sel),
    .i_data          (i_data),
    .wr_err          (wr_err4),
    .hdr_valid       (hdr_valid4),
    .hdr_ready       (hdr_ready),
    .release_hdr     (release_hdr),
    .increment       (increment),
    .nonce_exhausted (exh4),
    .chunk_1         (chunk_1_4),
    .chunk_2         (chunk_2_4),
    .difficulty      (difficulty_4),
    .nonce           (nonce4)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_byte(input int a);
    if (a < 64)
      return 32'(chunk_1[a*8 +: 8]);
    else if (a < 80)
      return 32'(chunk_2[(a-64)*8 +: 8]);
    else
      return 32'(difficulty[(a-80)*8 +: 8]);
  endfunction

  function automatic logic [31:0] obs(input int sel,
                                      input int idx);
    case (sel)
      O_WERR:  return 32'(wr_err);
      O_VALID: return 32'(hdr_valid);
      O_EXH:   return 32'(exh);
      O_NONCE: return nonce;
      O_NON4:  return nonce4;
      O_EXH4:  return 32'(exh4);
      O_WERR4: return 32'(wr_err4);
      default: return get_byte(idx);
    endcase
  endfunction

  task automatic push(input string tag, input int sel,
                      input int idx, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.idx = idx;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push_byte(input int a, input logic [7:0] v);
    push($sformatf("byte%0d", a), O_BYTE, a, 32'(v));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel, e.idx), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
    i_data_en   = 1'b0;
    clear       = 1'b0;
    hdr_ready   = 1'b0;
    release_hdr = 1'b0;
    increment   = 1'b0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    i_data_en  = 1'b1;
    i_data_sel = AW'(a);
    i_data     = d;
  endtask

  initial begin
    n_rst       = 1'b0;
    clear       = 1'b0;
    i_data_en   = 1'b0;
    i_data_sel  = '0;
    i_data      = '0;
    hdr_ready   = 1'b0;
    release_hdr = 1'b0;
    increment   = 1'b0;
    #12;
    push("rst_werr",  O_WERR,  0, 0);
    push("rst_valid", O_VALID, 0, 0);
    push("rst_exh",   O_EXH,   0, 0);
    push("rst_nonce", O_NONCE, 0, 0);
    push_byte(0, 8'h00);
    push_byte(111, 8'h00);
    drain();
    n_rst = 1'b1;

    // Fill all but the last byte; header stays incomplete.
    for (int a = 0; a < 111; a++) begin
      wr(a, 8'(a));
      push("fill_werr",  O_WERR,  0, 0);
      push("fill_valid", O_VALID, 0, 0);
      step();
    end
    push_byte(0, 8'h00);
    push_byte(50, 8'd50);
    push_byte(110, 8'd110);

    wr(112, 8'hEE);
    push("oor_werr",  O_WERR,  0, 1);
    push("oor_valid", O_VALID, 0, 0);
    step();
    push("idle_werr", O_WERR, 0, 0);
    step();

    wr(111, 8'h6F);
    push("last_werr",  O_WERR,  0, 0);
    push("last_valid", O_VALID, 0, 1);
    push_byte(111, 8'h6F);
    push_byte(0, 8'h00);
    step();

    wr(10, 8'hAA);
    push("ovw_werr",  O_WERR,  0, 0);
    push("ovw_valid", O_VALID, 0, 1);
    push_byte(10, 8'hAA);
    step();

    hdr_ready = 1'b1;
    push("mine_valid", O_VALID, 0, 0);
    step();

    wr(5, 8'h55);
    push("lock_werr", O_WERR, 0, 1);
    push_byte(5, 8'd5);
    step();

    release_hdr = 1'b1;
    push("rel_valid", O_VALID, 0, 1);
    step();

    wr(76, 8'hFE); step();
    wr(77, 8'hFF); step();
    wr(78, 8'hFF); step();
    wr(79, 8'hFF);
    push("nset_nonce", O_NONCE, 0, 32'hFFFF_FFFE);
    step();

    increment = 1'b1;
    push("inc_valid_ign", O_NONCE, 0, 32'hFFFF_FFFE);
    step();

    hdr_ready = 1'b1;
    push("mine2_valid", O_VALID, 0, 0);
    step();

    increment = 1'b1;
    push("inc1_nonce", O_NONCE, 0, 32'hFFFF_FFFF);
    push("inc1_exh",   O_EXH,   0, 0);
    push("inc1_n4",    O_NON4,  0, 32'h0000_0002);
    push("inc1_exh4",  O_EXH4,  0, 1);
    step();
    increment = 1'b1;
    push("inc2_nonce", O_NONCE, 0, 32'h0000_0000);
    push("inc2_exh",   O_EXH,   0, 1);
    push("inc2_n4",    O_NON4,  0, 32'h0000_0002);
    step();
    increment = 1'b1;
    push("inc3_nonce", O_NONCE, 0, 32'h0000_0000);
    push("inc3_exh",   O_EXH,   0, 1);
    step();

    release_hdr = 1'b1;
    push("rel2_valid", O_VALID, 0, 1);
    push("rel2_exh",   O_EXH,   0, 1);
    step();
    wr(76, 8'hFE);
    push("nwr_exh",   O_EXH,   0, 0);
    push("nwr_exh4",  O_EXH4,  0, 0);
    push("nwr_nonce", O_NONCE, 0, 32'h0000_00FE);
    push("nwr_n4",    O_NON4,  0, 32'h0000_00FE);
    step();

    // Clear wins over a same-cycle write.
    wr(3, 8'h33);
    clear = 1'b1;
    push("clr_werr",  O_WERR,  0, 0);
    push("clr_valid", O_VALID, 0, 0);
    push("clr_exh",   O_EXH,   0, 0);
    push("clr_nonce", O_NONCE, 0, 0);
    push_byte(3, 8'h00);
    push_byte(10, 8'h00);
    push_byte(111, 8'h00);
    step();

    wr(0, 8'h01);
    push("empty_valid", O_VALID, 0, 0);
    step();

    for (int a = 0; a < 112; a++) begin
      if (a == 76)
        wr(a, 8'hFE);
      else if (a > 76 && a < 80)
        wr(a, 8'h00);
      else
        wr(a, 8'(a));
      push("fill2_valid", O_VALID, 0, 32'(a == 111));
      step();
    end
    push("fill2_nonce", O_NON4, 0, 32'h0000_00FE);

    hdr_ready = 1'b1;
    push("mine3_valid", O_VALID, 0, 0);
    step();

    increment = 1'b1;
    push("s4_n4",    O_NON4,  0, 32'h0000_0102);
    push("s4_nonce", O_NONCE, 0, 32'h0000_00FF);
    push_byte(77, 8'h00);
    step();

    increment   = 1'b1;
    release_hdr = 1'b1;
    push("ri_n4",    O_NON4,  0, 32'h0000_0106);
    push("ri_nonce", O_NONCE, 0, 32'h0000_0100);
    push("ri_valid", O_VALID, 0, 1);
    step();

    wr(120, 8'h00);
    push("oor4_werr", O_WERR4, 0, 1);
    step();

    hdr_ready = 1'b1;
    push("mine4_valid", O_VALID, 0, 0);
    step();

    #3;
    n_rst = 1'b0;
    #1;
    push("arst_valid", O_VALID, 0, 0);
    push("arst_werr",  O_WERR,  0, 0);
    push("arst_exh",   O_EXH,   0, 0);
    push("arst_nonce", O_NONCE, 0, 0);
    push("arst_n4",    O_NON4,  0, 0);
    push_byte(0, 8'h00);
    push_byte(100, 8'h00);
    drain();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
